// File: rtl/hilo_unit.sv
// hilo_unit: launches a multiply/divide on the iterative units and commits the
// 64-bit result into the architectural HI/LO registers. Define HILO_MOVETO_EN
// to let mthi/mtlo (wr_hi/wr_lo) load HI/LO directly while idle.
module hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_mult,
  input  logic             op_div,
  input  logic             rd_hilo,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] mult_hi,
  input  logic [WIDTH-1:0] mult_lo,
  input  logic             mult_end,
  input  logic [WIDTH-1:0] div_hi,
  input  logic [WIDTH-1:0] div_lo,
  input  logic             div_end,
  input  logic             div_zero,
  output logic             mult_init,
  output logic             div_init,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall,
  output logic             div0_exc,
  output logic             op_err
);

  typedef enum logic [2:0] {
    IDLE,
    MULT_START,
    MULT_WAIT,
    DIV_START,
    DIV_WAIT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic request;
  logic mult_commit;
  logic div_commit;
  logic div_fault;
  logic wr_hi_en;
  logic wr_lo_en;

  assign request = op_mult | op_div;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Done flags are deliberately not looked at in the START states: the
  // previous operation's done may still be high there.
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_nxt unassigned and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (op_mult)     state_nxt = MULT_START;
        else if (op_div) state_nxt = DIV_START;
      end
      MULT_START: state_nxt = MULT_WAIT;
      MULT_WAIT:  if (mult_end) state_nxt = IDLE;
      DIV_START:  state_nxt = DIV_WAIT;
      DIV_WAIT:   if (div_end) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mult_init   = 1'b0;
    div_init    = 1'b0;
    mult_commit = 1'b0;
    div_commit  = 1'b0;
    div_fault   = 1'b0;
    case (state)
      MULT_START: mult_init   = 1'b1;
      MULT_WAIT:  mult_commit = mult_end;
      DIV_START:  div_init    = 1'b1;
      DIV_WAIT: begin
        div_commit = div_end & ~div_zero;
        div_fault  = div_end &  div_zero;
      end
      default: ;
    endcase
  end

  assign busy  = (state != IDLE);
  assign stall = busy & (rd_hilo | op_mult | op_div | wr_hi | wr_lo);

`ifdef HILO_MOVETO_EN
  assign wr_hi_en = ~busy & wr_hi;
  assign wr_lo_en = ~busy & wr_lo;
`else
  // Move-to path absent: the strobes only feed stall, wdata goes nowhere.
  assign wr_hi_en = 1'b0;
  assign wr_lo_en = 1'b0;
  logic unused_wdata;
  assign unused_wdata = ^wdata;
`endif

  // Commits only occur in WAIT states and moves only in IDLE, so the
  // branches below never compete for the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (mult_commit) begin
      hi <= mult_hi;
      lo <= mult_lo;
    end else if (div_commit) begin
      hi <= div_hi;
      lo <= div_lo;
    end else begin
      if (wr_hi_en) hi <= wdata;
      if (wr_lo_en) lo <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div0_exc <= 1'b0;
      op_err   <= 1'b0;
    end else begin
      div0_exc <= div_fault;
      op_err   <= busy & request;
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: directed and randomized checks of hilo_unit against a
// behavioural HI/LO model driven by plain signed arithmetic.
module tb_hilo_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_mult, op_div, rd_hilo, wr_hi, wr_lo;
  logic [W-1:0] wdata, mult_hi, mult_lo, div_hi, div_lo;
  logic         mult_end, div_end, div_zero;
  logic         mult_init, div_init, busy, stall, div0_exc, op_err;
  logic [W-1:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  always #5 clk = ~clk;

  hilo_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .op_mult(op_mult), .op_div(op_div), .rd_hilo(rd_hilo),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .mult_hi(mult_hi), .mult_lo(mult_lo), .mult_end(mult_end),
    .div_hi(div_hi), .div_lo(div_lo), .div_end(div_end), .div_zero(div_zero),
    .mult_init(mult_init), .div_init(div_init), .hi(hi), .lo(lo),
    .busy(busy), .stall(stall), .div0_exc(div0_exc), .op_err(op_err)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each cycle begins 1 time unit after the rising edge.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // One mult/div: request, done flag 'lat' cycles after the init cycle,
  // optional stale done in the START cycle, optional mfhi held under stall.
  task automatic run_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input bit stale, input bit rd, input string tag);
    int          sa, sb, busy_cnt;
    longint      prod;
    bit          zero, fire;
    logic [63:0] res, bus;
    sa   = a;
    sb   = b;
    zero = is_div && (b == 32'd0);
    if (!is_div) begin
      prod = longint'(sa) * longint'(sb);
      res  = prod;
    end else if (zero) begin
      res = 64'hDEAD_BEEF_CAFE_F00D;
    end else if (sa == int'(32'h8000_0000) && sb == -1) begin
      res = {32'd0, 32'h8000_0000};
    end else begin
      res = {32'(sa % sb), 32'(sa / sb)};
    end

    if (is_div) op_div = 1'b1;
    else        op_mult = 1'b1;
    next_cycle;
    op_div  = 1'b0;
    op_mult = 1'b0;
    check({tag, "/init"}, {mult_init, div_init}, is_div ? 2'b01 : 2'b10);

    busy_cnt = 0;
    for (int k = 0; k <= lat; k++) begin
      if (stale && k == 1)
        check({tag, "/stale"}, {busy, hi, lo}, {1'b1, exp_hi, exp_lo});
      if (busy) busy_cnt++;
      fire = (k == lat) || (stale && k == 0);
      bus  = (stale && k == 0) ? ~res : res;
      if (is_div) begin
        div_end  = fire;
        div_zero = zero;
        {div_hi, div_lo} = bus;
      end else begin
        mult_end = fire;
        {mult_hi, mult_lo} = bus;
      end
      rd_hilo = rd && (k >= 1);
      if (rd && k >= 1) begin
        #1;
        check({tag, "/stall_held"}, stall, 1'b1);
      end
      next_cycle;
    end
    mult_end = 1'b0;
    div_end  = 1'b0;
    div_zero = 1'b0;

    if (!(is_div && zero)) {exp_hi, exp_lo} = res;
    check({tag, "/hilo"}, {hi, lo}, {exp_hi, exp_lo});
    check({tag, "/busy_cycles"}, busy_cnt, lat + 1);
    check({tag, "/idle"}, {busy, div0_exc}, {1'b0, is_div && zero});
    if (rd) begin
      #1;
      check({tag, "/stall_release"}, stall, 1'b0);
      rd_hilo = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    {op_mult, op_div, rd_hilo, wr_hi, wr_lo, mult_end, div_end, div_zero} = '0;
    {wdata, mult_hi, mult_lo, div_hi, div_lo} = '0;
    next_cycle;
    check("reset_outputs", {mult_init, div_init, hi, lo, busy, stall, div0_exc, op_err}, '0);
    next_cycle;
    reset = 1'b0;
    rd_hilo = 1'b1;
    #1;
    check("idle_no_stall", {busy, stall}, 2'b00);
    rd_hilo = 1'b0;
    next_cycle;

    // 7 * -3, done 33 cycles after mult_init -> busy for 34 cycles.
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 33, 1'b0, 1'b0, "mult_7x-3");
    check("mult_7x-3/const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // Back-to-back divides; the second one divides by zero.
    run_op(1'b1, 32'd100, 32'd7, 20, 1'b0, 1'b0, "div_100/7");
    check("div_100/7/const", {hi, lo}, {32'd2, 32'd14});
    run_op(1'b1, 32'd5, 32'd0, 9, 1'b0, 1'b0, "div_5/0");
    check("div_5/0/const", {hi, lo}, {32'd2, 32'd14});
    next_cycle;
    check("div0_exc_single", div0_exc, 1'b0);

    // mfhi held from two cycles after op_mult until the cycle after done.
    run_op(1'b0, 32'h0001_2345, 32'hFFFF_0011, 12, 1'b0, 1'b1, "mult_stall");

    // Simultaneous requests: multiply wins, the divide is dropped silently.
    op_mult = 1'b1;
    op_div  = 1'b1;
    next_cycle;
    op_mult = 1'b0;
    op_div  = 1'b0;
    check("both/init", {mult_init, div_init, op_err}, 3'b100);
    next_cycle;
    op_div = 1'b1;
    #1;
    check("busy_req/stall", stall, 1'b1);
    next_cycle;
    op_div = 1'b0;
    check("busy_req/op_err", {op_err, div_init}, 2'b10);
    next_cycle;
    check("busy_req/op_err_pulse", {op_err, div_init}, 2'b00);
    {mult_hi, mult_lo} = 64'd6;
    mult_end = 1'b1;
    next_cycle;
    mult_end = 1'b0;
    {exp_hi, exp_lo} = 64'd6;
    check("both/commit", {busy, hi, lo}, {1'b0, exp_hi, exp_lo});
    next_cycle;
    check("both/no_div", {busy, div_init}, 2'b00);

    // Stale done flag in MULT_START must not commit.
    run_op(1'b0, 32'h0000_1234, 32'h0000_5678, 6, 1'b1, 1'b0, "mult_stale");
    run_op(1'b1, 32'hFFFF_FF00, 32'd9, 4, 1'b1, 1'b0, "div_stale");

    // Reset ten cycles into a multiply; a later done is ignored.
    op_mult = 1'b1;
    next_cycle;
    op_mult = 1'b0;
    repeat (10) next_cycle;
    reset = 1'b1;
    #1;
    check("midreset/async", {busy, hi, lo}, '0);
    next_cycle;
    reset = 1'b0;
    {mult_hi, mult_lo} = 64'h1111_2222_3333_4444;
    mult_end = 1'b1;
    next_cycle;
    mult_end = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    check("midreset/late_done", {busy, hi, lo}, '0);

    // Move-to strobes in IDLE, together with a multiply, and while busy.
    wr_lo = 1'b1;
    wdata = 32'h0000_1234;
    next_cycle;
    wr_lo = 1'b0;
`ifdef HILO_MOVETO_EN
    exp_lo = 32'h0000_1234;
`endif
    check("mtlo_idle", {hi, lo}, {exp_hi, exp_lo});
    wr_hi   = 1'b1;
    wdata   = 32'hA5A5_0001;
    op_mult = 1'b1;
    next_cycle;
    wr_hi   = 1'b0;
    op_mult = 1'b0;
`ifdef HILO_MOVETO_EN
    exp_hi = 32'hA5A5_0001;
`endif
    check("mthi_with_mult", {mult_init, hi}, {1'b1, exp_hi});
    next_cycle;
    wr_lo = 1'b1;
    wdata = 32'h0000_FFFF;
    #1;
    check("mtlo_busy/stall", stall, 1'b1);
    next_cycle;
    wr_lo = 1'b0;
    check("mtlo_busy/ignored", lo, exp_lo);
    {mult_hi, mult_lo} = 64'd15;
    mult_end = 1'b1;
    next_cycle;
    mult_end = 1'b0;
    {exp_hi, exp_lo} = 64'd15;
    check("mthi_with_mult/overwrite", {busy, hi, lo}, {1'b0, exp_hi, exp_lo});

    // Randomized operations against the arithmetic model.
    for (int i = 0; i < 12; i++) begin
      bit          is_div;
      logic [31:0] a, b;
      is_div = 1'($urandom_range(0, 1));
      a      = $urandom;
      b      = (is_div && $urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      run_op(is_div, a, b, int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
